// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 writeback path: requester indices,
// widths, the arbiter FSM state type and a modulo-5 increment helper.
package raisin64_pkg;

  localparam int DATA_W     = 64;
  localparam int RN_W       = 6;
  localparam int NUM_WB_REQ = 5;

  // Requester indices; round-robin order follows this numbering.
  localparam logic [2:0] WB_ALU1    = 3'd0;
  localparam logic [2:0] WB_ALU2    = 3'd1;
  localparam logic [2:0] WB_ADVINT  = 3'd2;
  localparam logic [2:0] WB_MEMUNIT = 3'd3;
  localparam logic [2:0] WB_BRANCH  = 3'd4;

  typedef enum logic {
    IDLE     = 1'b0,
    ADV_HALF = 1'b1
  } wb_state_e;

  // Next requester index, wrapping 4 -> 0 (out-of-range values fold to 0).
  function automatic logic [2:0] wb_next_idx(input logic [2:0] idx);
    return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Round-robin picker for the five writeback requesters: finds the first and
// second eligible requesters scanning upward from rr_ptr with wraparound.
module rr_pick5
  import raisin64_pkg::*;
(
  input  logic [NUM_WB_REQ-1:0] req_vec,
  input  logic [NUM_WB_REQ-1:0] mask,
  input  logic [2:0]            rr_ptr,
  output logic                  first_vld,
  output logic [2:0]            first_idx,
  output logic                  second_vld,
  output logic [2:0]            second_idx
);

  logic [NUM_WB_REQ-1:0] cand;
  logic [2:0]            scan;

  // Walk the five positions from the pointer, latching the first two hits.
  always_comb begin
    cand       = req_vec & mask;
    first_vld  = 1'b0;
    first_idx  = 3'd0;
    second_vld = 1'b0;
    second_idx = 3'd0;
    scan       = (rr_ptr > 3'd4) ? 3'd0 : rr_ptr;
    for (int k = 0; k < NUM_WB_REQ; k++) begin
      if (cand[scan]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = scan;
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = scan;
        end
      end
      scan = wb_next_idx(scan);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the two register-file write ports among alu1,
// alu2, advint, memunit and branch with round-robin priority. A two-result
// advint that only finds one free port is split over two cycles.
module wb_arbiter
  import raisin64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu1_wb_req,
  input  logic [RN_W-1:0]   alu1_wb_rn,
  input  logic [DATA_W-1:0] alu1_wb_data,
  input  logic              alu2_wb_req,
  input  logic [RN_W-1:0]   alu2_wb_rn,
  input  logic [DATA_W-1:0] alu2_wb_data,
  input  logic              advint_wb_req,
  input  logic [RN_W-1:0]   advint_wb_rn,
  input  logic [RN_W-1:0]   advint_wb_rn2,
  input  logic [DATA_W-1:0] advint_wb_data,
  input  logic [DATA_W-1:0] advint_wb_data2,
  input  logic              memunit_wb_req,
  input  logic [RN_W-1:0]   memunit_wb_rn,
  input  logic [DATA_W-1:0] memunit_wb_data,
  input  logic              branch_wb_req,
  input  logic [RN_W-1:0]   branch_wb_rn,
  input  logic [DATA_W-1:0] branch_wb_data,
  output logic              alu1_wb_ack,
  output logic              alu2_wb_ack,
  output logic              advint_wb_ack,
  output logic              memunit_wb_ack,
  output logic              branch_wb_ack,
  output logic              wr1_en,
  output logic              wr2_en,
  output logic [RN_W-1:0]   wr1_rn,
  output logic [RN_W-1:0]   wr2_rn,
  output logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] wr2_data,
  output logic [RN_W-1:0]   reg1_finished,
  output logic [RN_W-1:0]   reg2_finished
);

  wb_state_e             state, state_nxt;
  logic [2:0]            rr_ptr, rr_ptr_nxt, scan;
  logic [NUM_WB_REQ-1:0] req_vec, zero_req, slot_mask, ack_vec;
  logic [RN_W-1:0]       eff_rn   [NUM_WB_REQ];
  logic [DATA_W-1:0]     eff_data [NUM_WB_REQ];
  logic                  adv_double;
  logic                  first_vld, second_vld;
  logic [2:0]            first_idx, second_idx;
  logic                  w1_en, w2_en;
  logic [RN_W-1:0]       w1_rn, w2_rn;
  logic [DATA_W-1:0]     w1_data, w2_data;

  assign adv_double = (advint_wb_rn != '0) && (advint_wb_rn2 != '0);

  // Flatten requesters into index-ordered vectors; a one-destination advint
  // looks like an ordinary single-result unit using whichever rn is nonzero.
  always_comb begin
    req_vec                = '0;
    req_vec[WB_ALU1]       = alu1_wb_req;
    req_vec[WB_ALU2]       = alu2_wb_req;
    req_vec[WB_ADVINT]     = advint_wb_req;
    req_vec[WB_MEMUNIT]    = memunit_wb_req;
    req_vec[WB_BRANCH]     = branch_wb_req;
    eff_rn[WB_ALU1]        = alu1_wb_rn;
    eff_rn[WB_ALU2]        = alu2_wb_rn;
    eff_rn[WB_ADVINT]      = (advint_wb_rn != '0) ? advint_wb_rn : advint_wb_rn2;
    eff_rn[WB_MEMUNIT]     = memunit_wb_rn;
    eff_rn[WB_BRANCH]      = branch_wb_rn;
    eff_data[WB_ALU1]      = alu1_wb_data;
    eff_data[WB_ALU2]      = alu2_wb_data;
    eff_data[WB_ADVINT]    = (advint_wb_rn != '0) ? advint_wb_data : advint_wb_data2;
    eff_data[WB_MEMUNIT]   = memunit_wb_data;
    eff_data[WB_BRANCH]    = branch_wb_data;
  end

  // R0 results need no port; in ADV_HALF advint already owns port 1.
  always_comb begin
    zero_req = '0;
    for (int k = 0; k < NUM_WB_REQ; k++) begin
      zero_req[k] = req_vec[k] && (eff_rn[k] == '0);
    end
    slot_mask = ~zero_req;
    if (state == ADV_HALF) begin
      slot_mask[WB_ADVINT] = 1'b0;
    end
  end

  rr_pick5 u_pick (
    .req_vec    (req_vec),
    .mask       (slot_mask),
    .rr_ptr     (rr_ptr),
    .first_vld  (first_vld),
    .first_idx  (first_idx),
    .second_vld (second_vld),
    .second_idx (second_idx)
  );

  // Port assignment, acks and FSM next state; a duplicate rn on port 2 loses.
  always_comb begin
    ack_vec   = zero_req;
    state_nxt = state;
    w1_en     = 1'b0;
    w1_rn     = '0;
    w1_data   = '0;
    w2_en     = 1'b0;
    w2_rn     = '0;
    w2_data   = '0;
    if (state == IDLE) begin
      if (first_vld) begin
        if ((first_idx == WB_ADVINT) && adv_double) begin
          w1_en              = 1'b1;
          w1_rn              = advint_wb_rn;
          w1_data            = advint_wb_data;
          w2_en              = 1'b1;
          w2_rn              = advint_wb_rn2;
          w2_data            = advint_wb_data2;
          ack_vec[WB_ADVINT] = 1'b1;
        end else begin
          w1_en              = 1'b1;
          w1_rn              = eff_rn[first_idx];
          w1_data            = eff_data[first_idx];
          ack_vec[first_idx] = 1'b1;
          if (second_vld && (eff_rn[second_idx] != eff_rn[first_idx])) begin
            w2_en   = 1'b1;
            w2_rn   = eff_rn[second_idx];
            w2_data = eff_data[second_idx];
            if ((second_idx == WB_ADVINT) && adv_double) begin
              state_nxt = ADV_HALF;
            end else begin
              ack_vec[second_idx] = 1'b1;
            end
          end
        end
      end
    end else begin
      w1_en              = 1'b1;
      w1_rn              = advint_wb_rn2;
      w1_data            = advint_wb_data2;
      ack_vec[WB_ADVINT] = 1'b1;
      state_nxt          = IDLE;
      if (first_vld && (eff_rn[first_idx] != advint_wb_rn2)) begin
        w2_en              = 1'b1;
        w2_rn              = eff_rn[first_idx];
        w2_data            = eff_data[first_idx];
        ack_vec[first_idx] = 1'b1;
      end
    end
  end

  // Pointer moves past the last acked requester in scan order.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    scan       = rr_ptr;
    for (int k = 0; k < NUM_WB_REQ; k++) begin
      if (ack_vec[scan]) begin
        rr_ptr_nxt = wb_next_idx(scan);
      end
      scan = wb_next_idx(scan);
    end
  end

  // State, pointer and registered write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 3'd0;
      wr1_en   <= 1'b0;
      wr1_rn   <= '0;
      wr1_data <= '0;
      wr2_en   <= 1'b0;
      wr2_rn   <= '0;
      wr2_data <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      wr1_en   <= w1_en;
      wr1_rn   <= w1_rn;
      wr1_data <= w1_data;
      wr2_en   <= w2_en;
      wr2_rn   <= w2_rn;
      wr2_data <= w2_data;
    end
  end

  assign reg1_finished = wr1_en ? wr1_rn : '0;
  assign reg2_finished = wr2_en ? wr2_rn : '0;

  assign alu1_wb_ack    = ack_vec[WB_ALU1];
  assign alu2_wb_ack    = ack_vec[WB_ALU2];
  assign advint_wb_ack  = ack_vec[WB_ADVINT];
  assign memunit_wb_ack = ack_vec[WB_MEMUNIT];
  assign branch_wb_ack  = ack_vec[WB_BRANCH];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, a reset-during-split
// sequence, and random traffic against a slot-counting reference model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_q;
  logic [5:0]  rn_q [5];
  logic [63:0] data_q [5];
  logic [5:0]  rn2_q;
  logic [63:0] data2_q;
  logic [63:0] used_map;

  logic [4:0]  ack_bus;
  logic        alu1_ack, alu2_ack, adv_ack, mem_ack, br_ack;
  logic        wr1_en, wr2_en;
  logic [5:0]  wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  logic [63:0] wr1_data, wr2_data;

  int checks = 0;
  int passes = 0;
  int m_ptr;
  bit m_half;

  typedef struct {
    logic [4:0]      req;
    logic [4:0][5:0] rn;
    logic [5:0]      rnb;
    logic [4:0]      ack;
    int              s1;
    logic [5:0]      r1;
    int              s2;
    logic [5:0]      r2;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign ack_bus = {br_ack, mem_ack, adv_ack, alu2_ack, alu1_ack};

  wb_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu1_wb_req     (req_q[0]),
    .alu1_wb_rn      (rn_q[0]),
    .alu1_wb_data    (data_q[0]),
    .alu2_wb_req     (req_q[1]),
    .alu2_wb_rn      (rn_q[1]),
    .alu2_wb_data    (data_q[1]),
    .advint_wb_req   (req_q[2]),
    .advint_wb_rn    (rn_q[2]),
    .advint_wb_rn2   (rn2_q),
    .advint_wb_data  (data_q[2]),
    .advint_wb_data2 (data2_q),
    .memunit_wb_req  (req_q[3]),
    .memunit_wb_rn   (rn_q[3]),
    .memunit_wb_data (data_q[3]),
    .branch_wb_req   (req_q[4]),
    .branch_wb_rn    (rn_q[4]),
    .branch_wb_data  (data_q[4]),
    .alu1_wb_ack     (alu1_ack),
    .alu2_wb_ack     (alu2_ack),
    .advint_wb_ack   (adv_ack),
    .memunit_wb_ack  (mem_ack),
    .branch_wb_ack   (br_ack),
    .wr1_en          (wr1_en),
    .wr2_en          (wr2_en),
    .wr1_rn          (wr1_rn),
    .wr2_rn          (wr2_rn),
    .wr1_data        (wr1_data),
    .wr2_data        (wr2_data),
    .reg1_finished   (reg1_finished),
    .reg2_finished   (reg2_finished)
  );

  // Recognisable data word per source (5 = advint second result) and rn.
  function automatic logic [63:0] dval(input int src, input logic [5:0] rn);
    return {16'hC0DE, 8'(src), 2'b00, rn, 32'h1234_5678 ^ {26'd0, rn}};
  endfunction

  function automatic logic [153:0] pack_wr(input logic e1, input logic [5:0] r1, input logic [63:0] d1,
                                           input logic e2, input logic [5:0] r2, input logic [63:0] d2);
    return {e1, e1 ? r1 : 6'd0, e1 ? d1 : 64'd0,
            e2, e2 ? r2 : 6'd0, e2 ? d2 : 64'd0,
            e1 ? r1 : 6'd0, e2 ? r2 : 6'd0};
  endfunction

  function automatic logic [153:0] act_wr();
    return {wr1_en, wr1_en ? wr1_rn : 6'd0, wr1_en ? wr1_data : 64'd0,
            wr2_en, wr2_en ? wr2_rn : 6'd0, wr2_en ? wr2_data : 64'd0,
            reg1_finished, reg2_finished};
  endfunction

  function automatic vec_t mk(input logic [4:0] req, input logic [5:0] a0, input logic [5:0] a1,
                              input logic [5:0] a2, input logic [5:0] a3, input logic [5:0] a4,
                              input logic [5:0] ab, input logic [4:0] ack, input int s1,
                              input logic [5:0] r1, input int s2, input logic [5:0] r2);
    vec_t v;
    v.req = req;
    v.rn[0] = a0; v.rn[1] = a1; v.rn[2] = a2; v.rn[3] = a3; v.rn[4] = a4;
    v.rnb = ab; v.ack = ack; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [153:0] act, input logic [153:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Drive one table record, check acks mid-cycle and the writes after the edge.
  task automatic apply_stimulus(input vec_t v, input string name);
    logic [153:0] exp;
    req_q = v.req;
    for (int i = 0; i < 5; i++) begin
      rn_q[i]   = v.rn[i];
      data_q[i] = dval(i, v.rn[i]);
    end
    rn2_q   = v.rnb;
    data2_q = dval(5, v.rnb);
    @(negedge clk);
    check_output({name, "_ack"}, {149'd0, ack_bus}, {149'd0, v.ack});
    exp = pack_wr(v.s1 >= 0, v.r1, (v.s1 >= 0) ? dval(v.s1, v.r1) : 64'd0,
                  v.s2 >= 0, v.r2, (v.s2 >= 0) ? dval(v.s2, v.r2) : 64'd0);
    @(posedge clk);
    #1;
    check_output({name, "_wr"}, act_wr(), exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_q = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_half = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset_state", act_wr(), 154'd0);
  endtask

  task automatic pick_rn(input int zero_odds, output logic [5:0] rn);
    int r;
    rn = 6'd0;
    if ($urandom_range(0, zero_odds) != 0) begin
      for (int tries = 0; tries < 1000; tries++) begin
        r = $urandom_range(1, 63);
        if (!used_map[r]) begin
          used_map[r] = 1'b1;
          rn = 6'(r);
          break;
        end
      end
    end
  endtask

  // Idle units may post a new result; nonzero destinations stay unique.
  task automatic gen_requests();
    used_map = '0;
    for (int i = 0; i < 5; i++) begin
      if (req_q[i]) begin
        if (rn_q[i] != 0) used_map[rn_q[i]] = 1'b1;
        if (i == 2 && rn2_q != 0) used_map[rn2_q] = 1'b1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (!req_q[i] && $urandom_range(0, 1) == 1) begin
        req_q[i] = 1'b1;
        pick_rn(7, rn_q[i]);
        data_q[i] = {$urandom, $urandom};
        if (i == 2) begin
          pick_rn(5, rn2_q);
          data2_q = {$urandom, $urandom};
        end
      end
    end
  endtask

  // Reference: walk requesters from the pointer handing out free write slots.
  task automatic model_eval(output logic [4:0] ack, output logic [153:0] wr,
                            output int nptr, output bit nhalf);
    int slots, port, cnt, idx;
    logic        wen  [2];
    logic [5:0]  wrn  [2];
    logic [63:0] wdat [2];
    logic [5:0]  drn  [2];
    logic [63:0] ddat [2];
    ack = '0;
    nhalf = 1'b0;
    for (int p = 0; p < 2; p++) begin
      wen[p] = 1'b0; wrn[p] = '0; wdat[p] = '0; drn[p] = '0; ddat[p] = '0;
    end
    slots = m_half ? 1 : 2;
    port  = 0;
    if (m_half) begin
      wen[0] = 1'b1; wrn[0] = rn2_q; wdat[0] = data2_q; port = 1;
    end
    for (int k = 0; k < 5; k++) begin
      idx = (m_ptr + k) % 5;
      if (!req_q[idx]) continue;
      if (m_half && idx == 2) begin
        ack[2] = 1'b1;
        continue;
      end
      cnt = 0;
      if (rn_q[idx] != 0) begin
        drn[cnt] = rn_q[idx]; ddat[cnt] = data_q[idx]; cnt++;
      end
      if (idx == 2 && rn2_q != 0) begin
        drn[cnt] = rn2_q; ddat[cnt] = data2_q; cnt++;
      end
      if (cnt == 0) begin
        ack[idx] = 1'b1;
      end else if (cnt == 1 && slots > 0) begin
        wen[port] = 1'b1; wrn[port] = drn[0]; wdat[port] = ddat[0];
        port++; slots--; ack[idx] = 1'b1;
      end else if (cnt == 2 && slots == 2) begin
        wen[0] = 1'b1; wrn[0] = drn[0]; wdat[0] = ddat[0];
        wen[1] = 1'b1; wrn[1] = drn[1]; wdat[1] = ddat[1];
        slots = 0; ack[idx] = 1'b1;
      end else if (cnt == 2 && slots == 1) begin
        wen[port] = 1'b1; wrn[port] = drn[0]; wdat[port] = ddat[0];
        slots = 0; nhalf = 1'b1;
      end
    end
    nptr = m_ptr;
    for (int k = 0; k < 5; k++) begin
      idx = (m_ptr + k) % 5;
      if (ack[idx]) nptr = (idx + 1) % 5;
    end
    wr = pack_wr(wen[0], wrn[0], wdat[0], wen[1], wrn[1], wdat[1]);
  endtask

  initial begin
    logic [4:0]   eack;
    logic [153:0] ewr;
    int           nptr;
    bit           nhalf;

    req_q = '0;
    for (int i = 0; i < 5; i++) begin
      rn_q[i] = '0;
      data_q[i] = '0;
    end
    rn2_q = '0;
    data2_q = '0;
    used_map = '0;

    //            req       a0  a1  a2  a3  a4  ab  ack       s1 r1  s2  r2
    vecs.push_back(mk(5'b01001, 5,  0,  0,  9,  0,  0, 5'b01001, 0,  5,  3,  9));
    vecs.push_back(mk(5'b10000, 0,  0,  0,  0, 10,  0, 5'b10000, 4, 10, -1,  0));
    vecs.push_back(mk(5'b11111, 1,  2,  3,  9, 10,  4, 5'b00011, 0,  1,  1,  2));
    vecs.push_back(mk(5'b11100, 1,  2,  3,  9, 10,  4, 5'b00100, 2,  3,  5,  4));
    vecs.push_back(mk(5'b11000, 0,  0,  0,  9, 10,  0, 5'b11000, 3,  9,  4, 10));
    vecs.push_back(mk(5'b00001, 11, 0,  0,  0,  0,  0, 5'b00001, 0, 11, -1,  0));
    vecs.push_back(mk(5'b10110, 0, 12,  3,  0, 10,  4, 5'b00010, 1, 12,  2,  3));
    vecs.push_back(mk(5'b10100, 0,  0,  3,  0, 10,  4, 5'b10100, 5,  4,  4, 10));
    vecs.push_back(mk(5'b10001, 13, 0,  0,  0,  0,  0, 5'b10001, 0, 13, -1,  0));
    vecs.push_back(mk(5'b00101, 15, 0,  0,  0,  0, 14, 5'b00101, 0, 15,  5, 14));
    vecs.push_back(mk(5'b01110, 0, 16,  0,  0,  0,  0, 5'b01110, 1, 16, -1,  0));
    vecs.push_back(mk(5'b01100, 0,  0, 21, 20,  0, 22, 5'b01000, 3, 20,  2, 21));

    #12;
    check_output("reset_outputs", act_wr(), 154'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Now in the split state with advint holding rd2=22; reset mid-cycle.
    req_q = 5'b00100;
    #2;
    rst_n = 1'b0;
    req_q = '0;
    #1;
    check_output("reset_in_half", act_wr(), 154'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("no_rd2_after_reset", act_wr(), 154'd0);
    apply_stimulus(mk(5'b00100, 0, 0, 21, 0, 0, 22, 5'b00100, 2, 21, 5, 22), "adv_after_reset");

    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      gen_requests();
      model_eval(eack, ewr, nptr, nhalf);
      @(negedge clk);
      check_output($sformatf("rand%0d_ack", cyc), {149'd0, ack_bus}, {149'd0, eack});
      @(posedge clk);
      #1;
      check_output($sformatf("rand%0d_wr", cyc), act_wr(), ewr);
      m_ptr  = nptr;
      m_half = nhalf;
      for (int i = 0; i < 5; i++) begin
        if (eack[i]) req_q[i] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
